// File: rtl/r_mux_pkg.sv
// Shared types and helpers for the R-channel mux slice: RRESP encodings, FSM states,
// and the packing function that builds one skid-buffer payload word.
package r_mux_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [0:0] {
        IDLE,
        BURST
    } r_state_e;

    localparam int unsigned IdMaxW   = 32;
    localparam int unsigned DataMaxW = 1024;
    localparam int unsigned UserMaxW = 64;
    localparam int unsigned PackMaxW = IdMaxW + DataMaxW + 2 + 1 + UserMaxW;

    // Layout from LSB: ruser, rlast, rresp, rdata, rid. Fields must arrive zero-extended;
    // the caller truncates the result to its real payload width.
    function automatic logic [PackMaxW-1:0] pack_r_beat(
        input logic [IdMaxW-1:0]   rid,
        input logic [DataMaxW-1:0] rdata,
        input logic [1:0]          rresp,
        input logic                rlast,
        input logic [UserMaxW-1:0] ruser,
        input int unsigned         data_w,
        input int unsigned         user_w
    );
        logic [PackMaxW-1:0] beat;
        beat = PackMaxW'(ruser);
        beat |= PackMaxW'(rlast) << user_w;
        beat |= PackMaxW'(rresp) << (user_w + 1);
        beat |= PackMaxW'(rdata) << (user_w + 3);
        beat |= PackMaxW'(rid) << (user_w + 3 + data_w);
        return beat;
    endfunction

endpackage

// File: rtl/r_skid_buf.sv
// Generic 2-entry valid/ready register slice. Output comes straight from the head
// register; in_ready depends only on registered occupancy.
module r_skid_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             push, pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        push    = in_valid && in_ready;
        pop     = out_valid && out_ready;
        unique case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = in_data;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = in_data;
                end else if (push) begin
                    tail_d  = in_data;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_d  = tail_q;
                    count_d = 2'd1;
                end
            end
            default: count_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/r_mux_slice.sv
// Locks one slave R channel per burst (until RLAST) and forwards it through a skid slice.
// Optional R_MUX_BEAT_CNT_EN adds a master-side beat counter and an over-long burst flag.
module r_mux_slice
    import r_mux_pkg::*;
#(
    parameter int unsigned NUM_SLV    = 5,
    parameter int unsigned ID_WIDTH   = 6,
    parameter int unsigned MID_WIDTH  = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned USER_WIDTH = 6,
    parameter int unsigned SEL_W      = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_SLV*ID_WIDTH-1:0]    s_rid,
    input  logic [NUM_SLV*DATA_WIDTH-1:0]  s_rdata,
    input  logic [NUM_SLV*2-1:0]           s_rresp,
    input  logic [NUM_SLV-1:0]             s_rlast,
    input  logic [NUM_SLV*USER_WIDTH-1:0]  s_ruser,
    input  logic [NUM_SLV-1:0]             s_rvalid,
    output logic [NUM_SLV-1:0]             s_rready,
    output logic [MID_WIDTH-1:0]           m_rid,
    output logic [DATA_WIDTH-1:0]          m_rdata,
    output logic [1:0]                     m_rresp,
    output logic                           m_rlast,
    output logic [USER_WIDTH-1:0]          m_ruser,
    output logic                           m_rvalid,
    input  logic                           m_rready,
    input  logic [SEL_W-1:0]               r_slv_sel,
    input  logic                           r_hold,
    output logic                           burst_done,
    output logic                           sel_err
`ifdef R_MUX_BEAT_CNT_EN
    ,
    output logic [15:0]                    beat_cnt,
    output logic                           burst_len_err
`endif
);

    localparam int unsigned LastLsb = USER_WIDTH;
    localparam int unsigned RespLsb = USER_WIDTH + 1;
    localparam int unsigned DataLsb = USER_WIDTH + 3;
    localparam int unsigned IdLsb   = DataLsb + DATA_WIDTH;
    localparam int unsigned BeatW   = IdLsb + MID_WIDTH;

    r_state_e         state_q, state_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic             burst_done_q, burst_done_d;
    logic             sel_err_q, sel_err_d;

    logic [MID_WIDTH-1:0]  sel_rid;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic [1:0]            sel_rresp;
    logic                  sel_rlast;
    logic [USER_WIDTH-1:0] sel_ruser;
    logic                  sel_rvalid;
    logic                  buf_ready, slv_ready, accept, in_range;
    logic [BeatW-1:0]      beat_in, beat_out;

    assign in_range  = (32'(r_slv_sel) < NUM_SLV);
    // buf_ready comes from registered occupancy, so no m_rready -> s_rready path exists.
    assign slv_ready = (state_q == BURST) && !r_hold && buf_ready;

    always_comb begin
        sel_rid    = '0;
        sel_rdata  = '0;
        sel_rresp  = '0;
        sel_rlast  = 1'b0;
        sel_ruser  = '0;
        sel_rvalid = 1'b0;
        s_rready   = '0;
        for (int unsigned k = 0; k < NUM_SLV; k++) begin
            if (cur_sel_q == SEL_W'(k)) begin
                sel_rid     = s_rid[k*ID_WIDTH +: MID_WIDTH];
                sel_rdata   = s_rdata[k*DATA_WIDTH +: DATA_WIDTH];
                sel_rresp   = s_rresp[k*2 +: 2];
                sel_rlast   = s_rlast[k];
                sel_ruser   = s_ruser[k*USER_WIDTH +: USER_WIDTH];
                sel_rvalid  = s_rvalid[k];
                s_rready[k] = slv_ready;
            end
        end
        accept = slv_ready && sel_rvalid;
    end

    always_comb begin
        state_d      = state_q;
        cur_sel_d    = cur_sel_q;
        burst_done_d = 1'b0;
        sel_err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!r_hold) begin
                    if (in_range) begin
                        state_d   = BURST;
                        cur_sel_d = r_slv_sel;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
            end
            BURST: begin
                if (accept && sel_rlast) begin
                    state_d      = IDLE;
                    burst_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cur_sel_q    <= '0;
            burst_done_q <= 1'b0;
            sel_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_sel_q    <= cur_sel_d;
            burst_done_q <= burst_done_d;
            sel_err_q    <= sel_err_d;
        end
    end

    assign burst_done = burst_done_q;
    assign sel_err    = sel_err_q;

    assign beat_in = BeatW'(pack_r_beat(IdMaxW'(sel_rid), DataMaxW'(sel_rdata), sel_rresp,
                                        sel_rlast, UserMaxW'(sel_ruser), DATA_WIDTH, USER_WIDTH));

    r_skid_buf #(
        .WIDTH(BeatW)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .in_valid (accept),
        .in_ready (buf_ready),
        .in_data  (beat_in),
        .out_valid(m_rvalid),
        .out_ready(m_rready),
        .out_data (beat_out)
    );

    assign m_ruser = beat_out[USER_WIDTH-1:0];
    assign m_rlast = beat_out[LastLsb];
    assign m_rresp = beat_out[RespLsb +: 2];
    assign m_rdata = beat_out[DataLsb +: DATA_WIDTH];
    assign m_rid   = beat_out[IdLsb +: MID_WIDTH];

`ifdef R_MUX_BEAT_CNT_EN
    logic [15:0] beat_cnt_q, beat_cnt_d;
    logic [8:0]  burst_beats_q, burst_beats_d;
    logic        burst_len_err_q, burst_len_err_d;

    always_comb begin
        beat_cnt_d      = beat_cnt_q;
        burst_beats_d   = burst_beats_q;
        burst_len_err_d = 1'b0;
        if (m_rvalid && m_rready && (beat_cnt_q != 16'hFFFF)) begin
            beat_cnt_d = beat_cnt_q + 16'd1;
        end
        if (accept) begin
            if (sel_rlast) begin
                burst_beats_d = '0;
            end else begin
                // Flag fires on the 257th beat only; the counter parks just past it.
                burst_len_err_d = (burst_beats_q == 9'd256);
                if (burst_beats_q != 9'd257) begin
                    burst_beats_d = burst_beats_q + 9'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt_q      <= '0;
            burst_beats_q   <= '0;
            burst_len_err_q <= 1'b0;
        end else begin
            beat_cnt_q      <= beat_cnt_d;
            burst_beats_q   <= burst_beats_d;
            burst_len_err_q <= burst_len_err_d;
        end
    end

    assign beat_cnt      = beat_cnt_q;
    assign burst_len_err = burst_len_err_q;
`endif

endmodule
